// File: rtl/key_conditioner.sv
// Push-button front end: sync, 1 ms-tick debounce, press pulse and auto-repeat events per key.
// Pulses are registered and coincide with the debounced level edge; keys are fully independent.
module key_conditioner #(
  parameter int N_KEYS         = 5,
  parameter int TICK_DIV       = 48000,
  parameter int DEB_TICKS      = 20,
  parameter int RPT_DELAY      = 500,
  parameter int RPT_PERIOD     = 100,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic              clk_48mhz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_evt,
  output logic              tick_1ms
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int RMAX = ((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD) - 1;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] RDLY_LAST = (RPT_DELAY > 0) ? RW'(RPT_DELAY - 1) : '0;
  localparam logic [RW-1:0] RPER_LAST = RW'(RPT_PERIOD - 1);

  localparam logic [1:0] REL = 2'd0;
  localparam logic [1:0] DLY = 2'd1;
  localparam logic [1:0] RPT = 2'd2;

  logic [TW-1:0]     tcnt;
  logic [N_KEYS-1:0] norm;
  logic [N_KEYS-1:0] sync_a;
  logic [N_KEYS-1:0] s;

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tcnt == TICK_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tick_1ms = (tcnt == TICK_LAST);

  assign norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= norm;
      s      <= sync_a;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic          lvl;
    logic          prs;
    logic          evt;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [1:0]    st;
    logic          deb_done;
    logic          rise;
    logic          fall;

    // The level flips on the same edge the FSM sees rise/fall, so pulses align with it.
    assign deb_done = tick_1ms && (s[i] != lvl) && (dcnt == DEB_LAST);
    assign rise     = deb_done && s[i];
    assign fall     = deb_done && !s[i];

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
      if (!rst_n) begin
        lvl  <= 1'b0;
        dcnt <= '0;
      end else if (tick_1ms) begin
        if (s[i] == lvl) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          lvl  <= s[i];
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
      if (!rst_n) begin
        st   <= REL;
        rcnt <= '0;
        prs  <= 1'b0;
        evt  <= 1'b0;
      end else begin
        prs <= rise;
        evt <= rise;
        if (rise) begin
          st   <= (RPT_DELAY == 0) ? REL : DLY;
          rcnt <= '0;
        end else if (fall) begin
          // Release wins over a repeat landing on the same tick: no event after the fall.
          st   <= REL;
          rcnt <= '0;
        end else if (tick_1ms) begin
          case (st)
            DLY: begin
              if (rcnt == RDLY_LAST) begin
                evt  <= 1'b1;
                st   <= RPT;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            RPT: begin
              if (rcnt == RPER_LAST) begin
                evt  <= 1'b1;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            default: begin
              st   <= REL;
              rcnt <= '0;
            end
          endcase
        end
      end
    end

    assign key_level[i] = lvl;
    assign key_press[i] = prs;
    assign key_evt[i]   = evt;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with small tick/debounce/repeat parameters.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_raw;
  logic [4:0] key_raw_b;
  logic [4:0] key_level, key_press, key_evt;
  logic [4:0] key_level_b, key_press_b, key_evt_b;
  logic       tick_1ms, tick_1ms_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(5), .TICK_DIV(4), .DEB_TICKS(3), .RPT_DELAY(5), .RPT_PERIOD(2), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk_48mhz(clk), .rst_n(rst_n), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_evt(key_evt), .tick_1ms(tick_1ms)
  );

  key_conditioner #(
    .N_KEYS(5), .TICK_DIV(4), .DEB_TICKS(3), .RPT_DELAY(0), .RPT_PERIOD(2), .KEY_ACTIVE_LOW(1)
  ) dut_norpt (
    .clk_48mhz(clk), .rst_n(rst_n), .key_raw(key_raw_b),
    .key_level(key_level_b), .key_press(key_press_b), .key_evt(key_evt_b), .tick_1ms(tick_1ms_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat, gap, cnt, cnt2, mis;

    rst_n     = 1'b0;
    key_raw   = 5'h1f;
    key_raw_b = 5'h1f;
    cyc(3);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_evt", key_evt, 0);
    check("rst_tick", tick_1ms, 0);
    check("rst_norpt_outputs", {key_level_b, key_press_b, key_evt_b}, 0);

    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tick_1ms) cnt++;
    end
    check("tick_count_40cyc", cnt, 10);
    check("idle_level", key_level, 0);

    // Clean press on key 0 with repeats
    key_raw[0] = 1'b0;
    lat = 0; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (key_level[0]) break;
      if (key_press[0] || key_evt[0]) cnt++;
    end
    check_range("t1_press_latency", lat, 11, 14);
    check("t1_press_with_level", key_press[0], 1);
    check("t1_evt_with_level", key_evt[0], 1);
    check("t1_no_early_pulse", cnt, 0);
    @(negedge clk);
    check("t1_press_one_cycle", key_press[0], 0);
    gap = 1; cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      gap++;
      if (key_press[0]) cnt++;
      if (key_evt[0]) break;
    end
    check("t1_first_repeat_gap", gap, 20);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (key_press[0]) cnt++;
      if (key_evt[0]) break;
    end
    check("t1_second_repeat_gap", gap, 8);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (key_press[0]) cnt++;
      if (key_evt[0]) break;
    end
    check("t1_third_repeat_gap", gap, 8);
    check("t1_no_extra_press", cnt, 0);
    key_raw[0] = 1'b1;
    cyc(20);
    check("t1_released", key_level[0], 0);

    // Bounce on key 1: 6-cycle segments never span three ticks
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 6 == 0) key_raw[1] = ~key_raw[1];
      @(negedge clk);
      if (key_level[1] || key_press[1] || key_evt[1]) cnt++;
    end
    check("t2_bounce_quiet", cnt, 0);
    check("t2_raw_ends_low", key_raw[1], 0);
    cnt = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (key_press[1]) cnt++;
    end
    check("t2_single_press", cnt, 1);
    key_raw[1] = 1'b1;
    cyc(20);

    // Release of key 2
    key_raw[2] = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (key_level[2]) break;
    end
    check("t3_level_rose", key_level[2], 1);
    cyc(30 - lat);
    key_raw[2] = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (!key_level[2]) break;
    end
    check_range("t3_release_latency", lat, 11, 14);
    check("t3_no_evt_at_fall", key_evt[2], 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (key_evt[2] || key_press[2] || key_level[2]) cnt++;
    end
    check("t3_quiet_after_fall", cnt, 0);

    // Simultaneous keys 3 and 4
    key_raw[4:3] = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (key_press[3] || key_press[4]) break;
    end
    check("t4_joint_press", key_press[4:3], 3);
    cnt = 0; mis = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (key_evt[3] != key_evt[4]) mis++;
      if (key_evt[3]) cnt++;
    end
    check("t4_lockstep", mis, 0);
    check("t4_repeat_count", cnt, 2);
    key_raw[4:3] = 2'b11;
    cyc(20);

    // Reset in the middle of repeating
    key_raw[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (key_press[0]) break;
    end
    cyc(25);
    check("t5_held_before_reset", key_level[0], 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_outputs", {key_level, key_press, key_evt, tick_1ms}, 0);
    cyc(3);
    rst_n = 1'b1;
    lat = 0; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (key_press[0]) break;
      if (key_evt != 0 || key_level != 0) cnt++;
    end
    check_range("t5_press_after_reset", lat, 11, 14);
    check("t5_no_pulse_before", cnt, 0);
    key_raw[0] = 1'b1;
    cyc(20);

    // Repeat disabled instance
    key_raw_b[0] = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (key_evt_b[0]) cnt++;
      if (key_press_b[0]) cnt2++;
    end
    check("t6_single_evt", cnt, 1);
    check("t6_single_press", cnt2, 1);
    check("t6_level_held", key_level_b[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
